// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scancode constants, event/state types and the status-byte filter
//   PS2_EXT/PS2_BRK   prefix bytes; FLT_*  keyboard status bytes dropped in IDLE
//   kbd_event_t       {ext, rel, code}; kbd_state_t decoder states
package ps2_pkg;
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_BRK     = 8'hF0;
    localparam logic [7:0] FLT_ERR0    = 8'h00;
    localparam logic [7:0] FLT_BAT_OK  = 8'hAA;
    localparam logic [7:0] FLT_ACK     = 8'hFA;
    localparam logic [7:0] FLT_BAT_ERR = 8'hFC;
    localparam logic [7:0] FLT_RESEND  = 8'hFE;
    localparam logic [7:0] FLT_ERR1    = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_t;

    function automatic logic is_filtered(input logic [7:0] b);
        return b == FLT_ERR0 || b == FLT_BAT_OK || b == FLT_ACK ||
               b == FLT_BAT_ERR || b == FLT_RESEND || b == FLT_ERR1;
    endfunction
endpackage

// File: rtl/ps2_keyboard_ctrl_if.sv
// ps2_keyboard_ctrl_if: byte-receiver inputs and CPU-side event/status signals
//   master: drives rx_data/rx_valid/rx_err/rd_en/clr_flags/irq_en, reads the rest
//   slave:  the controller side
interface ps2_keyboard_ctrl_if #(parameter int DEPTH = 8);
    logic [7:0]                   rx_data;
    logic                         rx_valid;
    logic                         rx_err;
    logic                         rd_en;
    logic                         clr_flags;
    logic                         irq_en;
    logic [9:0]                   ev_data;
    logic                         ev_valid;
    logic [$clog2(DEPTH+1)-1:0]   ev_count;
    logic                         overflow;
    logic                         rx_error;
    logic                         irq;

    modport master (
        output rx_data, rx_valid, rx_err, rd_en, clr_flags, irq_en,
        input  ev_data, ev_valid, ev_count, overflow, rx_error, irq
    );
    modport slave (
        input  rx_data, rx_valid, rx_err, rd_en, clr_flags, irq_en,
        output ev_data, ev_valid, ev_count, overflow, rx_error, irq
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: show-ahead event FIFO
//   push/wr_data write, pop removes head; head is 0 when empty; count/full/empty status
//   A push while full is accepted only when a pop frees the slot in the same cycle.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  kbd_event_t                 wr_data,
    input  logic                       pop,
    output kbd_event_t                 head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    kbd_event_t    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_pop, do_push;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wr_data;
    end
endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl: set-2 scancode decoder with event FIFO, sticky flags and irq
//   clk, rst_n (async active-low); bus (slave): rx byte stream in, head event,
//   count, overflow/rx_error sticky flags and irq out
module ps2_keyboard_ctrl
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ps2_keyboard_ctrl_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    kbd_state_t   state, next_state;
    kbd_event_t   ev, head;
    logic         push, full, empty, timeout, ovf_set;
    logic [TW-1:0] tcnt;
    logic [$clog2(DEPTH+1)-1:0] count;

    assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
    // the FIFO accepts a push while full only alongside a pop, so that is the drop case
    assign ovf_set = push & full & ~bus.rd_en;

    always_comb begin
        next_state = state;
        push       = 1'b0;
        ev         = '{ext: 1'b0, rel: 1'b0, code: bus.rx_data};
        if (bus.rx_err) begin
            next_state = IDLE;
        end else if (bus.rx_valid) begin
            case (state)
                IDLE: begin
                    next_state = bus.rx_data == PS2_EXT ? EXT : bus.rx_data == PS2_BRK ? BRK : IDLE;
                    push       = bus.rx_data != PS2_EXT && bus.rx_data != PS2_BRK && !is_filtered(bus.rx_data);
                end
                EXT: begin
                    next_state = bus.rx_data == PS2_BRK ? EXT_BRK : bus.rx_data == PS2_EXT ? EXT : IDLE;
                    push       = bus.rx_data != PS2_BRK && bus.rx_data != PS2_EXT;
                    ev.ext     = 1'b1;
                end
                BRK: begin
                    next_state = IDLE;
                    push       = 1'b1;
                    ev.rel     = 1'b1;
                end
                default: begin
                    next_state = IDLE;
                    push       = 1'b1;
                    ev.ext     = 1'b1;
                    ev.rel     = 1'b1;
                end
            endcase
        end else if (state != IDLE && timeout) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tcnt         <= '0;
            bus.overflow <= 1'b0;
            bus.rx_error <= 1'b0;
        end else begin
            state        <= next_state;
            tcnt         <= (bus.rx_valid || bus.rx_err || state == IDLE || timeout) ? '0 : tcnt + 1'b1;
            bus.overflow <= ovf_set ? 1'b1 : bus.clr_flags ? 1'b0 : bus.overflow;
            bus.rx_error <= bus.rx_err ? 1'b1 : bus.clr_flags ? 1'b0 : bus.rx_error;
        end
    end

    ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (ev),
        .pop     (bus.rd_en),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign bus.ev_data  = head;
    assign bus.ev_valid = ~empty;
    assign bus.ev_count = count;
    assign bus.irq      = bus.irq_en & (~empty | bus.overflow | bus.rx_error);
endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// tb_ps2_keyboard_ctrl: directed scancode sequences with hand-computed expected events
module tb_ps2_keyboard_ctrl;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ps2_keyboard_ctrl_if #(.DEPTH(DEPTH)) bus ();

    ps2_keyboard_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.rx_err   = err;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
    endtask

    task automatic send_err();
        @(negedge clk);
        bus.rx_err = 1'b1;
        @(negedge clk);
        bus.rx_err = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [9:0] exp);
        chk(tag, 16'(bus.ev_data), 16'(exp));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic clr();
        bus.clr_flags = 1'b1;
        @(negedge clk);
        bus.clr_flags = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.rx_data   = '0;
        bus.rx_valid  = 1'b0;
        bus.rx_err    = 1'b0;
        bus.rd_en     = 1'b0;
        bus.clr_flags = 1'b0;
        bus.irq_en    = 1'b1;
        idle(3);
        chk("rst_data",  16'(bus.ev_data), 16'h0);
        chk("rst_valid", 16'(bus.ev_valid), 16'h0);
        chk("rst_count", 16'(bus.ev_count), 16'h0);
        chk("rst_ovf",   16'(bus.overflow), 16'h0);
        chk("rst_err",   16'(bus.rx_error), 16'h0);
        chk("rst_irq",   16'(bus.irq), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        send(8'h1C);
        chk("make_data",  16'(bus.ev_data), 16'h01C);
        chk("make_valid", 16'(bus.ev_valid), 16'h1);
        chk("make_count", 16'(bus.ev_count), 16'h1);
        chk("make_irq",   16'(bus.irq), 16'h1);
        pop_chk("make_pop", 10'h01C);
        chk("pop_valid", 16'(bus.ev_valid), 16'h0);
        chk("pop_data",  16'(bus.ev_data), 16'h0);
        chk("pop_irq",   16'(bus.irq), 16'h0);
        pop_chk("pop_empty", 10'h000);
        chk("pop_empty_cnt", 16'(bus.ev_count), 16'h0);

        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("seq_count", 16'(bus.ev_count), 16'h3);
        pop_chk("seq_brk",    10'h11C);
        pop_chk("seq_ext",    10'h275);
        pop_chk("seq_extbrk", 10'h375);

        send(8'hE0); send(8'hE0); send(8'h75);
        send(8'hF0); send(8'hE0);
        send(8'hE0); send(8'hAA);
        chk("misc_count", 16'(bus.ev_count), 16'h3);
        pop_chk("ext_repeat",  10'h275);
        pop_chk("brk_e0_code", 10'h1E0);
        pop_chk("ext_nofilt",  10'h2AA);

        send(8'hAA); send(8'hFA); send(8'h00); send(8'hFF);
        send(8'hE0); send_err();
        chk("err_count", 16'(bus.ev_count), 16'h0);
        chk("err_flag",  16'(bus.rx_error), 16'h1);
        chk("err_irq",   16'(bus.irq), 16'h1);
        bus.irq_en = 1'b0;
        #1;
        chk("err_irq_dis", 16'(bus.irq), 16'h0);
        bus.irq_en = 1'b1;
        send(8'h75);
        pop_chk("err_to_idle", 10'h075);
        clr();
        chk("clr_err", 16'(bus.rx_error), 16'h0);
        chk("clr_irq", 16'(bus.irq), 16'h0);
        send(8'h1C, 1'b1);
        chk("err_valid_cnt",  16'(bus.ev_count), 16'h0);
        chk("err_valid_flag", 16'(bus.rx_error), 16'h1);
        @(negedge clk);
        bus.clr_flags = 1'b1;
        bus.rx_err    = 1'b1;
        @(negedge clk);
        bus.clr_flags = 1'b0;
        bus.rx_err    = 1'b0;
        chk("set_wins_clr", 16'(bus.rx_error), 16'h1);
        clr();

        for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i));
        chk("full_count", 16'(bus.ev_count), 16'(DEPTH));
        chk("full_ovf",   16'(bus.overflow), 16'h1);
        @(negedge clk);
        bus.rx_data  = 8'h30;
        bus.rx_valid = 1'b1;
        bus.rd_en    = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rd_en    = 1'b0;
        chk("pushpop_count", 16'(bus.ev_count), 16'(DEPTH));
        for (int i = 1; i < DEPTH; i++) pop_chk($sformatf("order%0d", i), 10'(8'h10 + 8'(i)));
        pop_chk("order_last", 10'h030);
        chk("drain_count", 16'(bus.ev_count), 16'h0);
        chk("drain_irq",   16'(bus.irq), 16'h1);
        clr();
        chk("clr_ovf", 16'(bus.overflow), 16'h0);

        send(8'hE0);
        idle(TMO + 2);
        send(8'h1C);
        pop_chk("tmo_event", 10'h01C);
        chk("tmo_noerr", 16'(bus.rx_error), 16'h0);
        chk("tmo_noovf", 16'(bus.overflow), 16'h0);
        send(8'hE0);
        idle(TMO - 5);
        send(8'h75);
        pop_chk("pre_tmo_event", 10'h275);

        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(bus.ev_valid), 16'h0);
        chk("mid_rst_count", 16'(bus.ev_count), 16'h0);
        chk("mid_rst_data",  16'(bus.ev_data), 16'h0);
        chk("mid_rst_irq",   16'(bus.irq), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h1C);
        pop_chk("post_rst_make", 10'h01C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
